// File: rtl/init_seq_pkg.sv
// Shared state encoding and widths for the init_sequencer block.
package init_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    DELAY     = 3'd1,
    CLK_ON    = 3'd2,
    MEM_REL   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser, async active-low reset to 0.
// Latency: 2 clk edges. No backpressure.
// Backpressure: none, free-running.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/init_sequencer.sv
// Power-on / soft-reset sequencer: lock wait, settle delay, clock enable, staged reset release.
// Latency: clk_en 3+DELAY_CYCLES edges after lock, each release a further STAGE_GAP edges.
// Backpressure: none; optional lock monitor enabled by INIT_SEQ_LOCK_MONITOR_EN.
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter int DELAY_CYCLES = 255,
  parameter int STAGE_GAP    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               soft_rst_req,
  output logic               clk_en,
  output logic               mem_rst_n,
  output logic               core_rst_n,
  output logic               ready,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = $clog2(max_int(DELAY_CYCLES, STAGE_GAP) + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);

  logic             lock_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_take;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    soft_take = soft_rst_req &&
                (state_q == CLK_ON || state_q == MEM_REL || state_q == RUN);
    case (state_q)
      WAIT_LOCK: if (lock_s)              state_d = DELAY;
      DELAY:     if (cnt_q == DELAY_LAST) state_d = CLK_ON;
      CLK_ON:    if (cnt_q == GAP_LAST)   state_d = MEM_REL;
      MEM_REL:   if (cnt_q == GAP_LAST)   state_d = RUN;
      RUN:       state_d = RUN;
      default:   state_d = WAIT_LOCK;
    endcase
    if (soft_take) state_d = CLK_ON;
`ifdef INIT_SEQ_LOCK_MONITOR_EN
    // Lock loss outranks a simultaneous soft request and forces a full rerun.
    if (!lock_s && state_q != WAIT_LOCK) state_d = WAIT_LOCK;
`endif

    // Counter restarts on any state change, including a soft re-entry of CLK_ON.
    cnt_d = '0;
    if (state_d == state_q && !soft_take &&
        (state_q == DELAY || state_q == CLK_ON || state_q == MEM_REL))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      clk_en     <= 1'b0;
      mem_rst_n  <= 1'b0;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en     <= (state_d == CLK_ON) || (state_d == MEM_REL) || (state_d == RUN);
      mem_rst_n  <= (state_d == MEM_REL) || (state_d == RUN);
      core_rst_n <= (state_d == RUN);
      ready      <= (state_d == RUN);
    end
  end

  assign state = state_q;

endmodule
